jam_param: RTL and testbench
============================

JAM_PARAM -- requirements
Module: jam_param

Interface
REQ-001 Parameter N, default 8: number of workers and number of jobs; legal range 2..8.
REQ-002 Parameter COST_W, default 7: width of one cost entry.
REQ-003 Parameter CNT_W, default 4: width of MatchCount.
REQ-004 Derived constants:
- AW = clog2(N), the width of a worker/job index.
- SUM_W = COST_W + clog2(N), the width of a cost sum.
REQ-005 CLK  input  1: clock; all state changes on the rising edge.
REQ-006 RST  input  1: reset, synchronous, active-high.
REQ-007 START  input  1: single-cycle request to begin a job-assignment run.
REQ-008 W  output  AW: worker index of the cost-table read address.
REQ-009 J  output  AW: job index of the cost-table read address.
REQ-010 Cost  input  COST_W: cost of (W,J), valid combinationally in the same cycle W/J are driven.
REQ-011 Busy  output  1: high from START acceptance until Valid is asserted.
REQ-012 Valid  output  1: one-cycle pulse; result outputs are valid in this cycle.
REQ-013 MinCost  output  SUM_W: minimum total cost over all N! assignments.
REQ-014 MatchCount  output  CNT_W: number of assignments achieving MinCost, saturating.
REQ-015 BestJob  output  N*AW: the job assigned to worker i sits at bits [i*AW +: AW].

Function
REQ-016 The FSM has four states: IDLE, LOAD, PERM, DONE.
REQ-017 IDLE -> LOAD on an edge with START=1; START is ignored in every other state.
REQ-018 LOAD scan:
- Lasts exactly N*N cycles.
- W/J step row-major: (0,0), (0,1) .. (N-1,N-1).
- Cost is captured into an internal N x N register file at the end of each cycle.
REQ-019 W and J are 0 outside LOAD.
REQ-020 PERM entry: the permutation register p[0..N-1] starts at identity; the running minimum is set to all-ones and the running count to 0.
REQ-021 PERM evaluates one permutation per cycle:
- sum = sum over i of cost[i][p[i]], computed at SUM_W bits with no overflow possible.
- Next p is the lexicographic successor.
- PERM lasts exactly N! cycles, ending after the descending permutation.
REQ-022 Per-permutation update:
- sum < running min: min <= sum, count <= 1, best <= p.
- sum == running min: count <= count+1, saturating at 2^CNT_W-1; best is unchanged.
- Consequently BestJob is the lexicographically smallest minimal permutation.
REQ-023 PERM -> DONE after the last permutation; DONE -> IDLE after one cycle.
REQ-024 In DONE, MinCost, MatchCount and BestJob are registered from the final min/count/best, and Valid=1.
REQ-025 Valid is high exactly one cycle, N*N+N!+1 edges after the START-sampling edge.
REQ-026 Busy falls in the same cycle Valid rises.
REQ-027 MinCost, MatchCount and BestJob hold their values until the next DONE; they are not cleared by START.
REQ-028 START asserted in the DONE cycle is ignored; START asserted in the first IDLE cycle after DONE is accepted.

Reset
REQ-029 RST=1 at an edge forces:
- state IDLE;
- Busy=0, Valid=0, W=0, J=0, MinCost=0, MatchCount=0, BestJob=0;
- internal min/count/best/p cleared.
REQ-030 RST has priority over START in the same cycle.
REQ-031 RST asserted in LOAD or PERM aborts the run; no Valid is produced for the aborted run.

Verification
REQ-032 N=3, cost[w][j]=3w+j, START -> Valid at edge 16, MinCost=12, MatchCount=6, BestJob={2,1,0}, i.e. identity (worker0 job0).
REQ-033 N=4, cost 0 on the diagonal and 10 elsewhere -> MinCost=0, MatchCount=1, BestJob identity, Valid 41 edges after START.
REQ-034 N=3, cost[w][j]=0 if j==2-w else 5 -> MinCost=0, MatchCount=1, BestJob worker0=2, worker1=1, worker2=0.
REQ-035 N=8, COST_W=7, all costs 127:
- Result: MinCost=1016, MatchCount=15 (saturated), BestJob identity.
- Timing: Valid 64+40320+1 edges after START.
REQ-036 N=4, RST pulsed mid-PERM -> all outputs 0 next cycle and no Valid; a new START then gives the REQ-033 result with correct latency.
REQ-037 START held high continuously from IDLE through the run:
- Valid pulses once, then a second run starts in the following IDLE cycle.
- Busy=1 throughout each run.

Source files
------------

// File: rtl/jam_param_if.sv
// jam_param_if: host bus of the optimal job-assignment solver.
// Carries run control, the cost-table read port and the result.
interface jam_param_if #(
    parameter int N      = 8,
    parameter int COST_W = 7,
    parameter int CNT_W  = 4
);
    localparam int AW    = $clog2(N);
    localparam int SUM_W = COST_W + $clog2(N);

    logic              START;
    logic [AW-1:0]     W;
    logic [AW-1:0]     J;
    logic [COST_W-1:0] Cost;
    logic              Busy;
    logic              Valid;
    logic [SUM_W-1:0]  MinCost;
    logic [CNT_W-1:0]  MatchCount;
    logic [N*AW-1:0]   BestJob;

    modport master (
        output START, Cost,
        input  W, J, Busy, Valid,
        input  MinCost, MatchCount, BestJob
    );

    modport slave (
        input  START, Cost,
        output W, J, Busy, Valid,
        output MinCost, MatchCount, BestJob
    );
endinterface

// File: rtl/jam_param.sv
// jam_param: exhaustive N-worker / N-job assignment solver.
// Loads an N x N cost table, then scores all N! permutations.
module jam_param #(
    parameter int N      = 8,
    parameter int COST_W = 7,
    parameter int CNT_W  = 4
) (
    input logic        CLK,
    input logic        RST,
    jam_param_if.slave bus
);
    localparam int AW    = $clog2(N);
    localparam int SUM_W = COST_W + $clog2(N);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef logic [AW-1:0] idx_t;
    typedef enum logic [1:0] {IDLE, LOAD, PERM, DONE} state_t;

    state_t            state_q;
    state_t            state_d;
    idx_t              w_q;
    idx_t              j_q;
    logic [COST_W-1:0] cost_q [N][N];
    idx_t              p_q    [N];
    idx_t              p_d    [N];
    idx_t              swp    [N];
    idx_t              best_q [N];
    idx_t              k;
    idx_t              l;
    idx_t              src;
    logic [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]  min_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              load_last;
    logic              perm_last;
    logic              busy_q;
    logic              valid_q;
    logic [SUM_W-1:0]  min_cost_q;
    logic [CNT_W-1:0]  match_q;
    logic [N*AW-1:0]   best_job_q;

    assign load_last = (w_q == idx_t'(N - 1)) &&
                       (j_q == idx_t'(N - 1));

    assign bus.W          = (state_q == LOAD) ? w_q : '0;
    assign bus.J          = (state_q == LOAD) ? j_q : '0;
    assign bus.Busy       = busy_q;
    assign bus.Valid      = valid_q;
    assign bus.MinCost    = min_cost_q;
    assign bus.MatchCount = match_q;
    assign bus.BestJob    = best_job_q;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: START only matters in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.START) state_d = LOAD;
            LOAD:    if (load_last) state_d = PERM;
            PERM:    if (perm_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Row-major read address walk across the cost table.
    always_ff @(posedge CLK) begin
        if (RST) begin
            w_q <= '0;
            j_q <= '0;
        end else if (state_q == LOAD && !load_last) begin
            if (j_q == idx_t'(N - 1)) begin
                j_q <= '0;
                w_q <= w_q + idx_t'(1);
            end else begin
                j_q <= j_q + idx_t'(1);
            end
        end else begin
            w_q <= '0;
            j_q <= '0;
        end
    end

    // Capture each cost entry as it is addressed.
    always_ff @(posedge CLK) begin
        if (state_q == LOAD) cost_q[w_q][j_q] <= bus.Cost;
    end

    // Lexicographic successor of p; no ascent means p is the last one.
    always_comb begin
        perm_last = 1'b1;
        k         = '0;
        l         = '0;
        src       = '0;
        for (int i = 0; i < N - 1; i++) begin
            if (p_q[i] < p_q[i+1]) begin
                perm_last = 1'b0;
                k         = idx_t'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (idx_t'(i) > k && p_q[i] > p_q[k]) l = idx_t'(i);
        end
        swp    = p_q;
        swp[k] = p_q[l];
        swp[l] = p_q[k];
        p_d    = swp;
        for (int i = 0; i < N; i++) begin
            if (idx_t'(i) > k) begin
                src    = k + idx_t'(N - i);
                p_d[i] = swp[src];
            end
        end
    end

    // Total cost of the current permutation.
    always_comb begin
        sum = '0;
        for (int i = 0; i < N; i++) begin
            sum = sum + SUM_W'(cost_q[i][p_q[i]]);
        end
    end

    // Permutation walk with running minimum, tie count and best.
    always_ff @(posedge CLK) begin
        if (RST) begin
            min_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < N; i++) begin
                p_q[i]    <= '0;
                best_q[i] <= '0;
            end
        end else begin
            case (state_q)
                LOAD: begin
                    if (load_last) begin
                        min_q <= '1;
                        cnt_q <= '0;
                        for (int i = 0; i < N; i++) p_q[i] <= idx_t'(i);
                    end
                end
                PERM: begin
                    p_q <= p_d;
                    if (sum < min_q) begin
                        min_q  <= sum;
                        cnt_q  <= CNT_W'(1);
                        best_q <= p_q;
                    end else if (sum == min_q && cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake flags and result registers loaded from DONE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            min_cost_q <= '0;
            match_q    <= '0;
            best_job_q <= '0;
        end else begin
            valid_q <= (state_q == DONE);
            if (state_q == IDLE && bus.START) busy_q <= 1'b1;
            else if (state_q == DONE)         busy_q <= 1'b0;
            if (state_q == DONE) begin
                min_cost_q <= min_q;
                match_q    <= cnt_q;
                for (int i = 0; i < N; i++) begin
                    best_job_q[i*AW +: AW] <= best_q[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_jam_param.sv
// tb_jam_param: scoreboard bench for jam_param at N=3, N=4, N=8.
// Vector table plus hand sequences for reset, abort and START timing.
`timescale 1ns/1ps
module tb_jam_param;
    localparam int LAT3 = 9 + 6 + 1;
    localparam int LAT4 = 16 + 24 + 1;
    localparam int LAT8 = 64 + 40320 + 1;

    typedef struct {
        logic [15:0] mc;
        logic [7:0]  cnt;
        logic [31:0] bj;
        int          at;
    } exp_t;

    typedef struct {
        int          kind;
        logic [15:0] mc;
        logic [7:0]  cnt;
        logic [31:0] bj;
    } vec_t;

    logic clk = 1'b0;
    logic rst3, rst4, rst8;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   done3 = 0, done4 = 0, done8 = 0;
    logic [15:0] last_mc3;
    logic [31:0] last_bj3;
    exp_t q3[$], q4[$], q8[$];
    exp_t m3, m4, m8;
    logic [6:0] tab3 [3][3];
    logic [6:0] tab4 [4][4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    jam_param_if #(.N(3), .COST_W(7), .CNT_W(4)) b3 ();
    jam_param_if #(.N(4), .COST_W(7), .CNT_W(4)) b4 ();
    jam_param_if #(.N(8), .COST_W(7), .CNT_W(4)) b8 ();

    assign b3.Cost = tab3[b3.W][b3.J];
    assign b4.Cost = tab4[b4.W][b4.J];
    assign b8.Cost = 7'd127;

    jam_param #(.N(3), .COST_W(7), .CNT_W(4)) dut3 (
        .CLK(clk), .RST(rst3), .bus(b3));
    jam_param #(.N(4), .COST_W(7), .CNT_W(4)) dut4 (
        .CLK(clk), .RST(rst4), .bus(b4));
    jam_param #(.N(8), .COST_W(7), .CNT_W(4)) dut8 (
        .CLK(clk), .RST(rst8), .bus(b8));

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    function automatic int done_of(int id);
        if (id == 3) return done3;
        if (id == 4) return done4;
        return done8;
    endfunction

    task automatic wait_done(int id, int n, int budget);
        int k = 0;
        while (done_of(id) < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("done%0d_timeout", id),
            64'(done_of(id) >= n), 64'd1);
    endtask

    task automatic to_cyc(int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Scoreboard pops: one expectation per Valid pulse.
    always @(negedge clk) begin
        if (b3.Valid === 1'b1) begin
            if (q3.size() == 0) begin
                chk("valid3_unexpected", 64'd1, 64'd0);
            end else begin
                m3 = q3.pop_front();
                chk("lat3", cyc, m3.at);
                chk("min3", b3.MinCost, m3.mc);
                chk("cnt3", b3.MatchCount, m3.cnt);
                chk("best3", b3.BestJob, m3.bj);
                chk("busy3_at_valid", b3.Busy, 0);
                last_mc3 = m3.mc;
                last_bj3 = m3.bj;
                done3++;
            end
        end
    end

    always @(negedge clk) begin
        if (b4.Valid === 1'b1) begin
            if (q4.size() == 0) begin
                chk("valid4_unexpected", 64'd1, 64'd0);
            end else begin
                m4 = q4.pop_front();
                chk("lat4", cyc, m4.at);
                chk("min4", b4.MinCost, m4.mc);
                chk("cnt4", b4.MatchCount, m4.cnt);
                chk("best4", b4.BestJob, m4.bj);
                chk("busy4_at_valid", b4.Busy, 0);
                done4++;
            end
        end
    end

    always @(negedge clk) begin
        if (b8.Valid === 1'b1) begin
            if (q8.size() == 0) begin
                chk("valid8_unexpected", 64'd1, 64'd0);
            end else begin
                m8 = q8.pop_front();
                chk("lat8", cyc, m8.at);
                chk("min8", b8.MinCost, m8.mc);
                chk("cnt8", b8.MatchCount, m8.cnt);
                chk("best8", b8.BestJob, m8.bj);
                chk("busy8_at_valid", b8.Busy, 0);
                done8++;
            end
        end
    end

    function automatic void fill3(int kind);
        for (int w = 0; w < 3; w++) begin
            for (int j = 0; j < 3; j++) begin
                case (kind)
                    0: tab3[w][j] = 7'(3 * w + j);
                    1: tab3[w][j] = (j == 2 - w) ? 7'd0 : 7'd5;
                    2: tab3[w][j] = 7'd5;
                    3: tab3[w][j] = 7'(w * j);
                    4: tab3[w][j] = 7'd127;
                    5: tab3[w][j] = 7'((w + j) % 3);
                    default: tab3[w][j] = 7'($urandom_range(0, 3));
                endcase
            end
        end
    endfunction

    // Brute-force reference: permutations in lexicographic order.
    function automatic exp_t model3();
        exp_t e;
        int   s;
        int   mn = 1 << 30;
        int   c = 0;
        e.bj = '0;
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3; b++)
                for (int d = 0; d < 3; d++) begin
                    if (a != b && a != d && b != d) begin
                        s = tab3[0][a] + tab3[1][b] + tab3[2][d];
                        if (s < mn) begin
                            mn   = s;
                            c    = 1;
                            e.bj = 32'(a + b * 4 + d * 16);
                        end else if (s == mn && c < 15) begin
                            c++;
                        end
                    end
                end
        e.mc = 16'(mn);
        e.cnt = 8'(c);
        e.at = 0;
        return e;
    endfunction

    task automatic start3(input exp_t e);
        e.at = cyc + 1 + LAT3;
        q3.push_back(e);
        b3.START = 1'b1;
        @(negedge clk);
        b3.START = 1'b0;
    endtask

    task automatic start4(input exp_t e, input bit keep);
        e.at = cyc + 1 + LAT4;
        if (keep) q4.push_back(e);
        b4.START = 1'b1;
        @(negedge clk);
        b4.START = 1'b0;
    endtask

    task automatic run3();
        vec_t vt [6];
        exp_t e, e2;
        int   n = 0;
        int   s;
        logic [15:0] pmc;
        logic [31:0] pbj;
        vt[0] = '{0, 16'd12,  8'd6, 32'h24};
        vt[1] = '{1, 16'd0,   8'd1, 32'h06};
        vt[2] = '{2, 16'd15,  8'd6, 32'h24};
        vt[3] = '{3, 16'd1,   8'd1, 32'h06};
        vt[4] = '{4, 16'd381, 8'd6, 32'h24};
        vt[5] = '{5, 16'd0,   8'd1, 32'h18};
        for (int i = 0; i < 6; i++) begin
            fill3(vt[i].kind);
            e.mc = vt[i].mc;
            e.cnt = vt[i].cnt;
            e.bj = vt[i].bj;
            start3(e);
            n++;
            wait_done(3, n, 40);
        end
        for (int i = 0; i < 4; i++) begin
            fill3(99);
            start3(model3());
            n++;
            wait_done(3, n, 40);
        end
        // address scan, result hold and Busy during a run
        fill3(0);
        pmc = last_mc3;
        pbj = last_bj3;
        s = cyc + 1;
        start3(model3());
        n++;
        for (int kk = 0; kk < 9; kk++) begin
            chk("wj_scan", {b3.W, b3.J}, 64'((kk / 3) * 4 + kk % 3));
            if (kk == 2) begin
                chk("hold_min3", b3.MinCost, pmc);
                chk("hold_best3", b3.BestJob, pbj);
            end
            @(negedge clk);
        end
        chk("wj_perm", {b3.W, b3.J}, 0);
        to_cyc(s + 15);
        chk("busy3_done", b3.Busy, 1);
        chk("valid3_done", b3.Valid, 0);
        wait_done(3, n, 40);
        // START held high: back-to-back runs
        fill3(2);
        e = model3();
        s = cyc + 1;
        e.at = s + LAT3;
        q3.push_back(e);
        e2 = e;
        e2.at = s + LAT3 + 1 + LAT3;
        q3.push_back(e2);
        n += 2;
        b3.START = 1'b1;
        to_cyc(s + 10);
        chk("busy3_held", b3.Busy, 1);
        to_cyc(s + 17);
        chk("busy3_rerun", b3.Busy, 1);
        to_cyc(s + 18);
        b3.START = 1'b0;
        wait_done(3, n, 60);
        // START in the DONE cycle is ignored
        fill3(4);
        s = cyc + 1;
        start3(model3());
        n++;
        to_cyc(s + 15);
        b3.START = 1'b1;
        @(negedge clk);
        b3.START = 1'b0;
        wait_done(3, n, 40);
        repeat (40) @(negedge clk);
        chk("done_start_ignored", b3.Busy, 0);
    endtask

    task automatic run4();
        exp_t e;
        int   s;
        for (int w = 0; w < 4; w++)
            for (int j = 0; j < 4; j++)
                tab4[w][j] = (w == j) ? 7'd0 : 7'd10;
        e.mc = 16'd0;
        e.cnt = 8'd1;
        e.bj = 32'hE4;
        e.at = 0;
        start4(e, 1'b1);
        wait_done(4, 1, 60);
        // abort mid-PERM
        s = cyc + 1;
        start4(e, 1'b0);
        chk("busy4_run", b4.Busy, 1);
        to_cyc(s + 16 + 10);
        rst4 = 1'b1;
        @(negedge clk);
        rst4 = 1'b0;
        chk("abort_busy4", b4.Busy, 0);
        chk("abort_valid4", b4.Valid, 0);
        chk("abort_min4", b4.MinCost, 0);
        chk("abort_cnt4", b4.MatchCount, 0);
        chk("abort_best4", b4.BestJob, 0);
        chk("abort_w4", b4.W, 0);
        chk("abort_j4", b4.J, 0);
        repeat (50) @(negedge clk);
        start4(e, 1'b1);
        wait_done(4, 2, 60);
        // reset wins over START
        rst4 = 1'b1;
        b4.START = 1'b1;
        @(negedge clk);
        rst4 = 1'b0;
        b4.START = 1'b0;
        chk("rst_prio_busy4", b4.Busy, 0);
        chk("rst_prio_cnt4", b4.MatchCount, 0);
        repeat (50) @(negedge clk);
        chk("rst_prio_idle4", b4.Busy, 0);
    endtask

    task automatic run8();
        exp_t e;
        e.mc = 16'd1016;
        e.cnt = 8'd15;
        e.bj = '0;
        for (int i = 0; i < 8; i++) e.bj = e.bj | (32'(i) << (3 * i));
        e.at = cyc + 1 + LAT8;
        q8.push_back(e);
        b8.START = 1'b1;
        @(negedge clk);
        b8.START = 1'b0;
        wait_done(8, 1, LAT8 + 100);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst3 = 1'b1;
        rst4 = 1'b1;
        rst8 = 1'b1;
        b3.START = 1'b0;
        b4.START = 1'b0;
        b8.START = 1'b0;
        fill3(0);
        for (int w = 0; w < 4; w++)
            for (int j = 0; j < 4; j++)
                tab4[w][j] = 7'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy3", b3.Busy, 0);
        chk("rst_valid3", b3.Valid, 0);
        chk("rst_w3", b3.W, 0);
        chk("rst_j3", b3.J, 0);
        chk("rst_min3", b3.MinCost, 0);
        chk("rst_cnt3", b3.MatchCount, 0);
        chk("rst_best3", b3.BestJob, 0);
        chk("rst_busy8", b8.Busy, 0);
        chk("rst_valid8", b8.Valid, 0);
        rst3 = 1'b0;
        rst4 = 1'b0;
        rst8 = 1'b0;
        @(negedge clk);
        fork
            run3();
            run4();
            run8();
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
